axi_burst_addr_gen: RTL

- Per-beat address generator between the AXI4 AW/AR channel capture and the data-path write/read engine of the memory-model slave.
- Accepts one burst command (id, addr, len, size, burst) and emits one beat descriptor per data beat: address, byte-lane mask, beat index, last flag.
- Sized from the shared AXI width parameters so the DUT and the testbench agree on geometry.

---
 rtl/axi_burst_addr_gen_pkg.sv | 26 ++
 rtl/axi_beat_strb.sv | 35 +++
 rtl/axi_burst_addr_gen.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/axi_burst_addr_gen_pkg.sv
// Shared AXI geometry and burst encodings for the memory-model slave.
// The DUT and its testbench both take their default widths from here, so
// the two always agree on bus geometry.
package axi_burst_addr_gen_pkg;

    localparam int AXI_ID_WIDTH    = 6;
    localparam int AXI_ADDR_WIDTH  = 32;
    localparam int AXI_DATA_WIDTH  = 1024;
    localparam int AXI_LEN_WIDTH   = 8;
    localparam int AXI_STRB_WIDTH  = AXI_DATA_WIDTH / 8;
    localparam int AXI_BOUNDARY_4K = 4096;
    localparam int AXI_PAGE_BITS   = $clog2(AXI_BOUNDARY_4K);

    typedef enum logic [1:0] {
        BURST_FIXED = 2'd0,
        BURST_INCR  = 2'd1,
        BURST_WRAP  = 2'd2,
        BURST_RSVD  = 2'd3
    } burst_e;

    // A WRAP burst may only be 2, 4, 8 or 16 beats long.
    function automatic logic wrap_len_legal(input logic [AXI_LEN_WIDTH-1:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

endpackage

// File: rtl/axi_beat_strb.sv
// Combinational byte-lane mask for one beat.
// Lanes run from the beat's offset within the bus up to (not including) the
// next size-aligned boundary. Shared by the write and read beat paths.
// Ports:
//   i_addr_lo  address bits that select the byte lane
//   i_size     AxSIZE (bytes per beat = 1 << i_size)
//   o_strb     one bit per byte lane
module axi_beat_strb
    import axi_burst_addr_gen_pkg::*;
#(
    parameter  int STRB_WIDTH = AXI_STRB_WIDTH,
    localparam int OFF_W      = $clog2(STRB_WIDTH)
) (
    input  logic [OFF_W-1:0]      i_addr_lo,
    input  logic [2:0]            i_size,
    output logic [STRB_WIDTH-1:0] o_strb
);

    logic [31:0] w_bytes;
    logic [31:0] w_lo;
    logic [31:0] w_hi;

    always_comb begin
        w_bytes = 32'd1 << i_size;
        w_lo    = 32'(i_addr_lo);
        // A size wider than the bus lets w_hi run past the top lane; the
        // compare below then simply fills to the end of the bus.
        w_hi    = (w_lo & ~(w_bytes - 32'd1)) + w_bytes;
        o_strb  = '0;
        for (int i = 0; i < STRB_WIDTH; i++) begin
            o_strb[i] = (32'(i) >= w_lo) && (32'(i) < w_hi);
        end
    end

endmodule

// File: rtl/axi_burst_addr_gen.sv
// Per-beat address generator for the AXI memory-model slave.
// Takes one AW/AR burst command and walks it, one beat descriptor per cycle.
// Ports:
//   aclk, aresetn          clock, async active-low reset
//   cmd_*                  burst command (valid/ready, id, addr, len, size, burst)
//   beat_valid/beat_ready  beat descriptor handshake
//   beat_id/addr/strb/idx  descriptor of the current beat
//   beat_last              final beat of the burst
//   beat_err               burst is illegal (consumer answers SLVERR)
//
// state  | meaning
// IDLE   | no burst in progress, command accepted
// BURST  | presenting beats of the latched command
module axi_burst_addr_gen
    import axi_burst_addr_gen_pkg::*;
#(
    parameter  int ID_WIDTH   = AXI_ID_WIDTH,
    parameter  int ADDR_WIDTH = AXI_ADDR_WIDTH,
    parameter  int DATA_WIDTH = AXI_DATA_WIDTH,
    parameter  int LEN_WIDTH  = AXI_LEN_WIDTH,
    localparam int STRB_WIDTH = DATA_WIDTH / 8,
    localparam int OFF_W      = $clog2(STRB_WIDTH)
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ID_WIDTH-1:0]   cmd_id,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic [2:0]            cmd_size,
    input  logic [1:0]            cmd_burst,
    output logic                  beat_valid,
    input  logic                  beat_ready,
    output logic [ID_WIDTH-1:0]   beat_id,
    output logic [ADDR_WIDTH-1:0] beat_addr,
    output logic [STRB_WIDTH-1:0] beat_strb,
    output logic [LEN_WIDTH-1:0]  beat_idx,
    output logic                  beat_last,
    output logic                  beat_err
);

    typedef enum logic {ST_IDLE, ST_BURST} state_e;

    localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);

    state_e                r_state;
    logic                  r_beat_valid;
    logic [ID_WIDTH-1:0]   r_id;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [LEN_WIDTH-1:0]  r_len;
    logic [2:0]            r_size;
    burst_e                r_burst;
    logic [LEN_WIDTH-1:0]  r_idx;
    logic                  r_err;

    logic                  w_hs;
    logic                  w_last;
    logic                  w_cmd_ready;
    logic                  w_accept;
    burst_e                w_cmd_burst;
    logic [ADDR_WIDTH-1:0] w_cmd_bytes;
    logic [ADDR_WIDTH-1:0] w_cmd_last_byte;
    logic                  w_cmd_err;
    logic [ADDR_WIDTH-1:0] w_bytes;
    logic [ADDR_WIDTH-1:0] w_incr;
    logic [ADDR_WIDTH-1:0] w_span;
    logic [ADDR_WIDTH-1:0] w_lower;
    logic [ADDR_WIDTH-1:0] w_next_addr;
    logic [STRB_WIDTH-1:0] w_strb;

    assign w_hs   = r_beat_valid & beat_ready;
    assign w_last = r_beat_valid & (r_idx == r_len);
    // Gated by aresetn so the slave never looks ready while held in reset.
    assign w_cmd_ready = aresetn & ((r_state == ST_IDLE) | (w_hs & w_last));
    assign w_accept    = cmd_valid & w_cmd_ready;

    // Legality of the incoming command, judged once at acceptance.
    always_comb begin
        w_cmd_burst     = burst_e'(cmd_burst);
        w_cmd_bytes     = ONE << cmd_size;
        w_cmd_last_byte = (cmd_addr & ~(w_cmd_bytes - ONE))
                        + ((ADDR_WIDTH'(cmd_len) + ONE) << cmd_size) - ONE;
        w_cmd_err       = 1'b0;
        if (int'(cmd_size) > OFF_W)
            w_cmd_err = 1'b1;
        case (w_cmd_burst)
            BURST_RSVD: w_cmd_err = 1'b1;
            BURST_WRAP: begin
                if (!wrap_len_legal(8'(cmd_len)) || ((cmd_addr & (w_cmd_bytes - ONE)) != '0))
                    w_cmd_err = 1'b1;
            end
            BURST_INCR: begin
                if (cmd_addr[ADDR_WIDTH-1:AXI_PAGE_BITS] != w_cmd_last_byte[ADDR_WIDTH-1:AXI_PAGE_BITS])
                    w_cmd_err = 1'b1;
            end
            default: begin
                if (cmd_len > LEN_WIDTH'(15))
                    w_cmd_err = 1'b1;
            end
        endcase
    end

    // Next beat address. Illegal bursts fall back to INCR (or stay FIXED)
    // so the consumer can still drain len+1 beats.
    always_comb begin
        w_bytes     = ONE << r_size;
        w_incr      = (r_addr & ~(w_bytes - ONE)) + w_bytes;
        w_span      = (ADDR_WIDTH'(r_len) + ONE) << r_size;
        w_lower     = r_addr & ~(w_span - ONE);
        w_next_addr = w_incr;
        if (r_burst == BURST_FIXED)
            w_next_addr = r_addr;
        else if ((r_burst == BURST_WRAP) && !r_err && (w_incr == w_lower + w_span))
            w_next_addr = w_lower;
    end

    axi_beat_strb #(
        .STRB_WIDTH (STRB_WIDTH)
    ) u_beat_strb (
        .i_addr_lo (r_addr[OFF_W-1:0]),
        .i_size    (r_size),
        .o_strb    (w_strb)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state      <= ST_IDLE;
            r_beat_valid <= 1'b0;
            r_id         <= '0;
            r_addr       <= '0;
            r_len        <= '0;
            r_size       <= '0;
            r_burst      <= BURST_FIXED;
            r_idx        <= '0;
            r_err        <= 1'b0;
        end else if (w_accept) begin
            // Covers both IDLE and the no-bubble restart on a last beat.
            r_state      <= ST_BURST;
            r_beat_valid <= 1'b1;
            r_id         <= cmd_id;
            r_addr       <= cmd_addr;
            r_len        <= cmd_len;
            r_size       <= cmd_size;
            r_burst      <= w_cmd_burst;
            r_idx        <= '0;
            r_err        <= w_cmd_err;
        end else if (w_hs && !w_last) begin
            r_addr       <= w_next_addr;
            r_idx        <= r_idx + LEN_WIDTH'(1);
        end else if (w_hs) begin
            r_state      <= ST_IDLE;
            r_beat_valid <= 1'b0;
        end
    end

    assign cmd_ready  = w_cmd_ready;
    assign beat_valid = r_beat_valid;
    assign beat_id    = r_id;
    assign beat_addr  = r_addr;
    assign beat_idx   = r_idx;
    assign beat_last  = w_last;
    assign beat_err   = r_beat_valid & r_err;
    assign beat_strb  = r_beat_valid ? w_strb : '0;

endmodule
